dither_dpwm_gen: RTL

Parametrised successor to the 9-bit dithered DPWM front end. It takes a DUTY_W-bit duty command and splits it into an integer part for a counter-based DPWM and a fractional part for dither. The dither pattern advances once per switching period, not once per clock. The block produces the PWM gate signal directly, with period-synchronous (glitch-free) duty updates and no carry wrap at full scale. It sits between the digital compensator output and the power-stage gate drivers.

---
 rtl/dither_dpwm_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/dither_dpwm_gen.sv
// Dithered counter-based DPWM: integer duty drives the counter compare, the fraction dithers +1 per period.
// Optional dead-time gate pair (pwm_hs/pwm_ls) is built when DPWM_DEADTIME_EN is defined.
module dither_dpwm_gen #(
    parameter int DUTY_W      = 9,
    parameter int DITHER_BITS = 3
`ifdef DPWM_DEADTIME_EN
    ,parameter int DT_W       = 4
`endif
) (
    input  logic                            clk_in,
    input  logic                            rst,
    input  logic [DUTY_W-1:0]               d_n_input,
    input  logic                            d_valid,
`ifdef DPWM_DEADTIME_EN
    input  logic [DT_W-1:0]                 dt_cfg,
    output logic                            pwm_hs,
    output logic                            pwm_ls,
`endif
    output logic                            period_start,
    output logic [DUTY_W-DITHER_BITS:0]     ditherin,
    output logic [DITHER_BITS-1:0]          dith_cnt,
    output logic                            pwm_out
);
    localparam int CNT_W = DUTY_W - DITHER_BITS;

    logic [CNT_W-1:0]       r_cnt;
    logic [DUTY_W-1:0]      r_shadow;
    logic [DITHER_BITS-1:0] r_dith;
    logic [CNT_W:0]         r_ditherin;
    logic                   r_pwm;

    logic                   w_tc;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [DUTY_W-1:0]      w_shadow_nxt;
    logic [DITHER_BITS-1:0] w_dith_nxt;
    logic                   w_dbit;
    logic [CNT_W:0]         w_eff_nxt;
    logic [CNT_W:0]         w_ditherin_nxt;
    logic                   w_pwm_nxt;

    function automatic logic [DITHER_BITS-1:0] f_bitrev(input logic [DITHER_BITS-1:0] v);
        logic [DITHER_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < DITHER_BITS; i++) r[i] = v[DITHER_BITS-1-i];
        return r;
    endfunction

    assign w_tc         = &r_cnt;
    assign w_cnt_nxt    = r_cnt + 1'b1;
    // Shadow next-value so a strobe in the TC cycle still reaches the next period.
    assign w_shadow_nxt = d_valid ? d_n_input : r_shadow;
    assign w_dith_nxt   = w_tc ? r_dith + 1'b1 : r_dith;
    assign w_dbit       = f_bitrev(w_dith_nxt) < w_shadow_nxt[DITHER_BITS-1:0];
    // One extra bit so full-scale integer plus dither reaches 100% instead of wrapping.
    assign w_eff_nxt    = {1'b0, w_shadow_nxt[DUTY_W-1:DITHER_BITS]} + {{CNT_W{1'b0}}, w_dbit};
    assign w_ditherin_nxt = w_tc ? w_eff_nxt : r_ditherin;
    assign w_pwm_nxt    = {1'b0, w_cnt_nxt} < w_ditherin_nxt;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_dith     <= '0;
            r_ditherin <= '0;
            r_pwm      <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_shadow   <= w_shadow_nxt;
            r_dith     <= w_dith_nxt;
            r_ditherin <= w_ditherin_nxt;
            r_pwm      <= w_pwm_nxt;
        end
    end

    assign period_start = (r_cnt == '0) & ~rst;
    assign ditherin     = r_ditherin;
    assign dith_cnt     = r_dith;
    assign pwm_out      = r_pwm;

`ifdef DPWM_DEADTIME_EN
    logic [DT_W-1:0] r_dt;
    logic [DT_W-1:0] r_run;
    logic            r_hs;
    logic            r_ls;
    logic [DT_W-1:0] w_dt_nxt;
    logic [DT_W-1:0] w_run_nxt;

    assign w_dt_nxt  = w_tc ? dt_cfg : r_dt;
    // Cycles since the last pwm_out edge, saturating so any dt_cfg is eventually reached.
    assign w_run_nxt = (w_pwm_nxt != r_pwm) ? '0 : ((&r_run) ? r_run : r_run + 1'b1);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_dt  <= '1;
            r_run <= '0;
            r_hs  <= 1'b0;
            r_ls  <= 1'b0;
        end else begin
            r_dt  <= w_dt_nxt;
            r_run <= w_run_nxt;
            r_hs  <= w_pwm_nxt & (w_run_nxt >= w_dt_nxt);
            r_ls  <= ~w_pwm_nxt & (w_run_nxt >= w_dt_nxt);
        end
    end

    assign pwm_hs = r_hs;
    assign pwm_ls = r_ls;
`endif
endmodule
